coverfloat_bitpattern_scanner: RTL and testbench
================================================

# coverfloat_bitpattern_scanner

Multi-cycle, parametrised bit-pattern analyser for the coverage collector. It computes, in a single MSB-to-LSB pass, all of these metrics on an operand of run-time-selectable width:

- leading zeros and leading ones
- trailing zeros and trailing ones
- longest run of ones
- signed checker run length

It scans CHUNK bits per cycle behind a valid/ready handshake, so wide significands (quad, 113 bits; intermediate products up to 256 bits) are analysed without a single deep combinational loop.

## Interface
Parameters:
- MAX_W, 256: maximum operand width; must be a multiple of CHUNK.
- CHUNK, 16: bits examined per scan cycle; must be a power of 2 and ≥ 1.
- CW, $clog2(MAX_W+1): counter and width-field width.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand offered.
- in_ready  out  1  block can accept; high only in IDLE.
- in_val  in  MAX_W  operand; bits at index ≥ in_width are ignored.
- in_width  in  CW  active width, legal range 1..MAX_W.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts.
- out_lz, out_lo, out_tz, out_to, out_longest1  out  CW each  leading-zero, leading-one, trailing-zero, trailing-one and longest-ones counts.
- out_checker  out  CW+1  signed checker run length: negative if the first run is ones, positive if zeros, 0 if the value is not a checker pattern.
- out_err  out  1  in_width was 0 or greater than MAX_W.

## Operation
FSM has three states: IDLE, SCAN, DONE.

IDLE:
- in_ready = 1.
- On in_valid && in_ready:
  - Left-justify the operand: latch in_val << (MAX_W − in_width).
  - Load remaining = in_width.
  - Clear the accumulators; go to SCAN.
- If in_width is illegal: set err, zero all counts, go straight to DONE.

SCAN:
- Each cycle consumes the top min(CHUNK, remaining) bits of the shift register, MSB first.
- Then shift left by CHUNK and set remaining −= consumed.
- Go to DONE when remaining reaches 0.
- Accumulators update bit-serially within the chunk (combinational loop over CHUNK bits):
  - Leading count of the first bit: increments until the first bit change, then freezes.
  - Current run length and current run polarity.
  - On each run end: update longest1 if the run was ones. Set checker_bad if the completed run length ≠ the first run length.
  - Trailing counts are the final run length, assigned to tz or to by the final polarity; the other is 0.
- Finalisation when entering DONE: close the final run.
  - checker = 0 if any of these hold: checker_bad; final run > first run; first run > (width >> 1); width < 2.
  - Otherwise checker = −first_run if the first bit is 1, else +first_run.
  - out_lz / out_lo: leading count goes to the output matching the first-bit polarity; the other is 0.

DONE:
- out_valid = 1; all outputs are registered and stable.
- On out_valid && out_ready, go to IDLE.

Count widths: CW bits hold values up to MAX_W, so there is no saturation. Arithmetic is unsigned, except out_checker, which is two's complement.

## Timing
Reset:
- Reset in any state forces IDLE at that edge: in_ready = 1, out_valid = 0, all result outputs and out_err = 0.
- An in-flight operand is discarded; no stale result is ever presented.

Latency:
- Handshake accepted at edge T, N = ceil(in_width / CHUNK). SCAN occupies N cycles; out_valid is high from edge T+N+1.
- Illegal width: out_valid from edge T+1.

Handshake:
- in_ready is 0 in SCAN and DONE. After the output handshake at edge D, in_ready = 1 from D+1.
- Minimum initiation interval is N+2 cycles.

Ordering and stability:
- Results appear in strict acceptance order, one in flight.
- in_val and in_width are sampled only at the accept edge; later changes have no effect.
- While out_ready = 0, all outputs hold indefinitely.

Simultaneous out_ready and a new in_valid in DONE: the new operand is not accepted until the IDLE cycle.

## Test plan
1. width=24, val=0x00F000 (runs 8/4/12) -> lz=8, lo=0, tz=12, to=0, longest1=4, checker=0. out_valid at T+3.
2. Checker patterns:
   - width=10, val=0x0CC -> checker=+2, lz=2, tz=2, longest1=2.
   - width=7, val=0b0001110 (partial final run) -> checker=+3, lz=3, tz=1, longest1=3.
   - width=24, val=0xF0F0F0 -> checker=−4, lo=4, tz=4.
3. width=256, all ones -> lo=256, to=256, longest1=256, lz=tz=0, checker=0 (run > 128). out_valid at T+17.
4. Illegal widths:
   - width=0 -> out_err=1, all counts 0, out_valid at T+1.
   - width=257 -> same response.
   - width=1, val=1 -> lo=1, to=1, longest1=1, checker=0, err=0.
5. Backpressure and masking: hold out_ready=0 for 5 cycles -> outputs constant, in_ready=0; then handshake -> in_ready=1 next cycle. Garbage in in_val bits above width has no effect.
6. Reset mid-operation: assert rst_n=0 during the 5th SCAN cycle of a width-256 operand -> next edge in_ready=1, out_valid=0, counts 0. The next operand produces the correct, uncontaminated result.

Source files
------------

// File: rtl/coverfloat_bitpattern_scanner_if.sv
// Operand/result handshake bundle between the coverage collector and the scanner.
interface coverfloat_bitpattern_scanner_if #(
  parameter int MAX_W = 256,
  parameter int CW    = $clog2(MAX_W + 1)
) ();
  logic             in_valid;
  logic             in_ready;
  logic [MAX_W-1:0] in_val;
  logic [CW-1:0]    in_width;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_lz;
  logic [CW-1:0]    out_lo;
  logic [CW-1:0]    out_tz;
  logic [CW-1:0]    out_to;
  logic [CW-1:0]    out_longest1;
  logic [CW:0]      out_checker;
  logic             out_err;

  modport master (
    output in_valid, in_val, in_width, out_ready,
    input  in_ready, out_valid, out_lz, out_lo, out_tz, out_to,
           out_longest1, out_checker, out_err
  );

  modport slave (
    input  in_valid, in_val, in_width, out_ready,
    output in_ready, out_valid, out_lz, out_lo, out_tz, out_to,
           out_longest1, out_checker, out_err
  );
endinterface

// File: rtl/coverfloat_bitpattern_scanner.sv
// Multi-cycle MSB-first run analyser: leading/trailing counts, longest ones run
// and signed checker run length, CHUNK bits per cycle.
module coverfloat_bitpattern_scanner #(
  parameter int MAX_W = 256,
  parameter int CHUNK = 16,
  parameter int CW    = $clog2(MAX_W + 1)
) (
  input logic clk,
  input logic rst_n,
  coverfloat_bitpattern_scanner_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [CW-1:0] MAX_W_CW = CW'(MAX_W);
  localparam logic [CW-1:0] CHUNK_CW = CW'(CHUNK);
  localparam logic [CW-1:0] ONE_CW   = CW'(1);
  localparam logic [CW-1:0] TWO_CW   = CW'(2);

  state_t           state_q;
  logic             in_ready_q, out_valid_q, err_q;
  logic [MAX_W-1:0] sr_q;
  logic [CW-1:0]    rem_q, width_q;
  logic             first_bit_q, pol_q, first_done_q, bad_q;
  logic [CW-1:0]    run_q, first_q, long_q;
  logic [CW-1:0]    lz_q, lo_q, tz_q, to_q, longest1_q;
  logic [CW:0]      checker_q;

  logic             pol_d, first_done_d, bad_d, bit_v, chk_ok;
  logic [CW-1:0]    run_d, first_d, long_d, rem_d, consumed;
  logic [CW-1:0]    lead_fin, long_fin;
  logic [CW:0]      checker_fin;
  logic [CW-1:0]    shift_amt;
  logic [MAX_W-1:0] aligned;

  assign shift_amt = MAX_W_CW - bus.in_width;
  assign aligned   = bus.in_val << shift_amt;

  // Bit-serial run tracking across the active bits of the current chunk.
  always_comb begin
    pol_d        = pol_q;
    run_d        = run_q;
    first_d      = first_q;
    first_done_d = first_done_q;
    long_d       = long_q;
    bad_d        = bad_q;
    bit_v        = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      if (CW'(i) < rem_q) begin
        bit_v = sr_q[MAX_W-1-i];
        if (bit_v == pol_d) begin
          run_d = run_d + ONE_CW;
        end else begin
          if (pol_d && (run_d > long_d)) long_d = run_d;
          if (first_done_d) begin
            if (run_d != first_d) bad_d = 1'b1;
          end else begin
            first_d      = run_d;
            first_done_d = 1'b1;
          end
          pol_d = bit_v;
          run_d = ONE_CW;
        end
      end
    end
    consumed = (rem_q < CHUNK_CW) ? rem_q : CHUNK_CW;
    rem_d    = rem_q - consumed;
    // A single-run operand never closed its first run inside the loop.
    lead_fin = first_done_d ? first_d : run_d;
    long_fin = (pol_d && (run_d > long_d)) ? run_d : long_d;
    chk_ok   = !bad_d && (run_d <= lead_fin) && (lead_fin <= (width_q >> 1))
               && (width_q >= TWO_CW);
    if (!chk_ok)          checker_fin = '0;
    else if (first_bit_q) checker_fin = -{1'b0, lead_fin};
    else                  checker_fin = {1'b0, lead_fin};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      sr_q         <= '0;
      rem_q        <= '0;
      width_q      <= '0;
      first_bit_q  <= 1'b0;
      pol_q        <= 1'b0;
      first_done_q <= 1'b0;
      bad_q        <= 1'b0;
      run_q        <= '0;
      first_q      <= '0;
      long_q       <= '0;
      lz_q         <= '0;
      lo_q         <= '0;
      tz_q         <= '0;
      to_q         <= '0;
      longest1_q   <= '0;
      checker_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            in_ready_q <= 1'b0;
            if ((bus.in_width == '0) || (bus.in_width > MAX_W_CW)) begin
              err_q       <= 1'b1;
              lz_q        <= '0;
              lo_q        <= '0;
              tz_q        <= '0;
              to_q        <= '0;
              longest1_q  <= '0;
              checker_q   <= '0;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              sr_q         <= aligned;
              rem_q        <= bus.in_width;
              width_q      <= bus.in_width;
              first_bit_q  <= aligned[MAX_W-1];
              pol_q        <= aligned[MAX_W-1];
              first_done_q <= 1'b0;
              bad_q        <= 1'b0;
              run_q        <= '0;
              first_q      <= '0;
              long_q       <= '0;
              state_q      <= SCAN;
            end
          end
        end
        SCAN: begin
          sr_q         <= sr_q << CHUNK;
          rem_q        <= rem_d;
          pol_q        <= pol_d;
          run_q        <= run_d;
          first_q      <= first_d;
          first_done_q <= first_done_d;
          long_q       <= long_d;
          bad_q        <= bad_d;
          if (rem_d == '0) begin
            err_q       <= 1'b0;
            lz_q        <= first_bit_q ? '0 : lead_fin;
            lo_q        <= first_bit_q ? lead_fin : '0;
            tz_q        <= pol_d ? '0 : run_d;
            to_q        <= pol_d ? run_d : '0;
            longest1_q  <= long_fin;
            checker_q   <= checker_fin;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_lz       = lz_q;
  assign bus.out_lo       = lo_q;
  assign bus.out_tz       = tz_q;
  assign bus.out_to       = to_q;
  assign bus.out_longest1 = longest1_q;
  assign bus.out_checker  = checker_q;
  assign bus.out_err      = err_q;
endmodule

// File: tb/tb_coverfloat_bitpattern_scanner.sv
// Randomised bench for the bit-pattern scanner against a run-list reference model.
module tb_coverfloat_bitpattern_scanner;
  localparam int MAX_W = 256;
  localparam int CHUNK = 16;
  localparam int CW    = $clog2(MAX_W + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  coverfloat_bitpattern_scanner_if #(.MAX_W(MAX_W), .CW(CW)) bus_if ();

  coverfloat_bitpattern_scanner #(.MAX_W(MAX_W), .CHUNK(CHUNK), .CW(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  typedef struct {
    int lz; int lo; int tz; int to; int l1; int chk; int err;
  } res_t;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL txn %0d %s got %0d expected %0d", txn, tag, got, exp);
    end
  endtask

  function automatic logic [MAX_W-1:0] rand_vec();
    logic [MAX_W-1:0] v;
    for (int i = 0; i < MAX_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Split the active bits into a list of run lengths, then read every metric off it.
  function automatic res_t model(input int w, input logic [MAX_W-1:0] v);
    res_t r;
    int   runs[$];
    int   cur, last_pol;
    bit   first, ok;
    r.lz = 0; r.lo = 0; r.tz = 0; r.to = 0; r.l1 = 0; r.chk = 0; r.err = 0;
    if (w < 1 || w > MAX_W) begin
      r.err = 1;
      return r;
    end
    first = v[w-1];
    cur = 0;
    for (int k = w - 1; k >= 0; k--) begin
      if (k != w - 1 && v[k] != v[k+1]) begin
        runs.push_back(cur);
        cur = 0;
      end
      cur++;
    end
    runs.push_back(cur);
    if (first) r.lo = runs[0]; else r.lz = runs[0];
    last_pol = int'(first) ^ ((runs.size() - 1) % 2);
    if (last_pol == 1) r.to = runs[runs.size()-1]; else r.tz = runs[runs.size()-1];
    foreach (runs[j]) if ((int'(first) ^ (j % 2)) == 1 && runs[j] > r.l1) r.l1 = runs[j];
    ok = (w >= 2) && (runs[0] <= w / 2) && (runs[runs.size()-1] <= runs[0]);
    for (int j = 0; j < runs.size() - 1; j++) if (runs[j] != runs[0]) ok = 0;
    if (ok) r.chk = first ? -runs[0] : runs[0];
    return r;
  endfunction

  task automatic check_zero_outputs();
    check("rst_in_ready", int'(bus_if.in_ready), 1);
    check("rst_out_valid", int'(bus_if.out_valid), 0);
    check("rst_lz", int'(bus_if.out_lz), 0);
    check("rst_lo", int'(bus_if.out_lo), 0);
    check("rst_tz", int'(bus_if.out_tz), 0);
    check("rst_to", int'(bus_if.out_to), 0);
    check("rst_longest1", int'(bus_if.out_longest1), 0);
    check("rst_checker", int'(bus_if.out_checker), 0);
    check("rst_err", int'(bus_if.out_err), 0);
  endtask

  // Called #1 after a rising edge with the DUT idle; returns in the same phase, idle again.
  task automatic do_op(input int w, input logic [MAX_W-1:0] v, input int stall);
    res_t        e;
    int          lat, exp_lat;
    logic [CW:0] exp_chk;
    txn++;
    e = model(w, v);
    exp_chk = (CW+1)'(e.chk);
    check("in_ready_idle", int'(bus_if.in_ready), 1);
    bus_if.in_valid = 1'b1;
    bus_if.in_width = CW'(w);
    bus_if.in_val   = v;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    bus_if.in_val   = rand_vec();
    bus_if.in_width = CW'($urandom);
    // lat = number of edges after the accept edge whose update raised out_valid
    lat = 0;
    while (!bus_if.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    exp_lat = (e.err != 0) ? 0 : (w + CHUNK - 1) / CHUNK;
    check("latency", lat, exp_lat);
    repeat (stall) begin
      @(posedge clk); #1;
    end
    check("in_ready_busy", int'(bus_if.in_ready), 0);
    check("out_valid_held", int'(bus_if.out_valid), 1);
    check("lz", int'(bus_if.out_lz), e.lz);
    check("lo", int'(bus_if.out_lo), e.lo);
    check("tz", int'(bus_if.out_tz), e.tz);
    check("to", int'(bus_if.out_to), e.to);
    check("longest1", int'(bus_if.out_longest1), e.l1);
    check("checker", int'(bus_if.out_checker), int'(exp_chk));
    check("err", int'(bus_if.out_err), e.err);
    $display("txn %0d w=%0d lat=%0d lz=%0d lo=%0d tz=%0d to=%0d l1=%0d chk=%0d err=%0d",
             txn, w, lat, bus_if.out_lz, bus_if.out_lo, bus_if.out_tz, bus_if.out_to,
             bus_if.out_longest1, $signed(bus_if.out_checker), bus_if.out_err);
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.out_ready = 1'b0;
    check("in_ready_after", int'(bus_if.in_ready), 1);
    check("out_valid_drop", int'(bus_if.out_valid), 0);
  endtask

  task automatic reset_mid_scan();
    txn++;
    bus_if.in_valid = 1'b1;
    bus_if.in_width = CW'(MAX_W);
    bus_if.in_val   = rand_vec();
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_zero_outputs();
    $display("txn %0d reset during scan in_ready=%0d out_valid=%0d",
             txn, bus_if.in_ready, bus_if.out_valid);
  endtask

  initial begin
    logic [MAX_W-1:0] ones, v, mask;
    int w, r, mode, fb;
    ones = '1;
    bus_if.in_valid  = 1'b0;
    bus_if.in_val    = '0;
    bus_if.in_width  = '0;
    bus_if.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs();
    rst_n = 1'b1;

    do_op(24, 256'h00F000, 0);
    do_op(10, 256'h0CC, 0);
    do_op(7, 256'b0001110, 0);
    do_op(24, 256'hF0F0F0, 0);
    do_op(256, ones, 0);
    do_op(0, rand_vec(), 0);
    do_op(257, rand_vec(), 0);
    do_op(1, 256'h1, 0);
    do_op(24, (rand_vec() << 24) | 256'h00F000, 5);
    do_op(256, ones, 2);
    reset_mid_scan();
    do_op(24, 256'hF0F0F0, 0);

    for (int t = 0; t < 150; t++) begin
      mode = $urandom_range(0, 4);
      v = rand_vec();
      w = $urandom_range(1, MAX_W);
      if (mode == 1 || mode == 2) begin
        w  = $urandom_range(2, 64);
        r  = $urandom_range(1, w / 2 + 1);
        fb = $urandom_range(0, 1);
        for (int k = 0; k < w; k++) v[w-1-k] = 1'(fb ^ ((k / r) % 2));
        if (mode == 2) v[$urandom_range(0, w - 1)] ^= 1'b1;
      end else if (mode == 3) begin
        mask = ones >> (MAX_W - w);
        v = ($urandom_range(0, 1) != 0) ? (v | mask) : (v & ~mask);
      end else if (mode == 4) begin
        w = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(MAX_W + 1, 511);
      end
      do_op(w, v, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
